// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the elastic register pipeline (reg_pipe_elastic).
package reg_pipe_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: data/valid register with load, drain and clear.
module reg_pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int unsigned          WIDTH   = 8,
   parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] src_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= RST_VAL;
      end else begin
         if (clear) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= 1'b1;
         end else if (drain) begin
            valid <= 1'b0;
         end
         // Data only changes on an accepted load; emptying leaves the old word in place.
         if (load && !clear) begin
            data <= src_data;
         end
      end
   end

endmodule

// File: rtl/reg_pipe_elastic.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake and bubble collapse.
// Optional synchronous flush port enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipe_elastic
   import reg_pipe_pkg::*;
#(
   parameter int unsigned          WIDTH   = 8,
   parameter int unsigned          DEPTH   = 4,
   parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef REG_PIPE_FLUSH_EN
   input  logic                          flush,
`endif
   input  logic [WIDTH-1:0]              in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [clog2(DEPTH+1)-1:0]     occupancy
);

   localparam int unsigned OCC_W = clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] d   [DEPTH];
   logic [WIDTH-1:0] src [DEPTH];
   logic             clear;
   logic             in_fire;
   logic             out_fire;

`ifdef REG_PIPE_FLUSH_EN
   assign clear = flush;
`else
   assign clear = 1'b0;
`endif

   // Advance chain resolves from the output end back towards the input.
   always_comb begin
      adv  = '0;
      load = '0;
      adv[DEPTH-1] = v[DEPTH-1] & out_ready;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         adv[DEPTH-1-i] = v[DEPTH-1-i] & (~v[DEPTH-i] | adv[DEPTH-i]);
      end
      in_ready = ~v[0] | adv[0];
      in_fire  = in_valid & in_ready;
      load[0]  = in_fire;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         load[i] = adv[i-1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_src_in
         assign src[k] = in_data;
      end else begin : g_src_prev
         assign src[k] = d[k-1];
      end

      reg_pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .clear    (clear),
         .load     (load[k]),
         .drain    (adv[k]),
         .src_data (src[k]),
         .valid    (v[k]),
         .data     (d[k])
      );
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign out_fire  = v[DEPTH-1] & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occupancy <= '0;
      end else if (clear) begin
         occupancy <= '0;
      end else begin
         case ({in_fire, out_fire})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Scoreboard bench for reg_pipe_elastic: a timestamped word queue predicts
// occupancy, in_ready, out_valid timing and output order.
module tb_reg_pipe_elastic;

   localparam int unsigned     WIDTH   = 8;
   localparam int unsigned     DEPTH   = 4;
   localparam logic [7:0]      RST_VAL = 8'h3C;

   typedef struct {
      logic [7:0]  data;
      int unsigned t;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  occupancy;
`ifdef REG_PIPE_FLUSH_EN
   logic        flush = 1'b0;
`endif

   item_t       q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned last_dep = 0;
   int unsigned ready_at;
   logic        exp_ov;
   logic        exp_ir;

   reg_pipe_elastic #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .RST_VAL (RST_VAL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef REG_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // A word reaches the output DEPTH cycles after acceptance, or one cycle
   // after the previous word departs, whichever is later.
   always @(negedge clk) begin
      if (rst) begin
         exp_ir = (q.size() < DEPTH) || out_ready;
         exp_ov = 1'b0;
         if (q.size() > 0) begin
            ready_at = q[0].t + DEPTH;
            if (last_dep + 1 > ready_at) ready_at = last_dep + 1;
            exp_ov = (cyc >= ready_at);
         end
         check("occupancy", 32'(occupancy), 32'(q.size()));
         check("in_ready", 32'(in_ready), 32'(exp_ir));
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         if (out_valid && out_ready) begin
            if (q.size() > 0) begin
               check("out_data", 32'(out_data), 32'(q[0].data));
               void'(q.pop_front());
               last_dep = cyc;
            end else begin
               check("unexpected_output", 32'(1), 32'(0));
            end
         end
      end
   end

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl,
                       output bit acc, output bit ov);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
`ifdef REG_PIPE_FLUSH_EN
      flush     = fl;
`endif
      @(negedge clk);
      #1;
      ov  = out_valid;
      acc = iv && in_ready && rst && !fl;
      if (fl) q.delete();
      else if (acc) q.push_back('{data: id, t: cyc});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ordy);
      bit a, o;
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, a, o);
   endtask

   task automatic measure_latency(output int lat);
      bit a, o;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, a, o);
         if (o && lat == 0) lat = i;
      end
   endtask

   initial begin
      bit          acc, ov, have;
      int          lat, idx;
      logic [7:0]  words [6];
      logic [7:0]  pend;

      repeat (3) @(posedge clk);
      #3;
      check("reset_out_valid", 32'(out_valid), 32'(0));
      check("reset_occupancy", 32'(occupancy), 32'(0));
      check("reset_out_data", 32'(out_data), 32'(RST_VAL));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_in_ready", 32'(in_ready), 32'(1));

      // latency into an empty pipe
      step(1'b1, 8'hA5, 1'b1, 1'b0, acc, ov);
      check("latency_accept", 32'(acc), 32'(1));
      measure_latency(lat);
      check("latency", 32'(lat), 32'(DEPTH));

      // back-to-back stream
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 8'(i), 1'b1, 1'b0, acc, ov);
         check("stream_accept", 32'(acc), 32'(1));
      end
      idle(DEPTH + 2, 1'b1);
      check("stream_drained", 32'(q.size()), 32'(0));

      // backpressure: only DEPTH words fit
      for (int i = 0; i < 6; i++) words[i] = 8'h30 + 8'(i);
      idx = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, words[idx], 1'b0, 1'b0, acc, ov);
         if (acc) idx++;
      end
      check("bp_accepted", 32'(idx), 32'(DEPTH));
      check("bp_occupancy", 32'(occupancy), 32'(DEPTH));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      for (int i = 0; i < 20 && idx < 6; i++) begin
         step(1'b1, words[idx], 1'b1, 1'b0, acc, ov);
         if (acc) idx++;
      end
      check("bp_all_accepted", 32'(idx), 32'(6));
      idle(DEPTH + 3, 1'b1);
      check("bp_drained", 32'(q.size()), 32'(0));

      // bubble collapse under stall
      step(1'b1, 8'h71, 1'b0, 1'b0, acc, ov);
      idle(2, 1'b0);
      step(1'b1, 8'h72, 1'b0, 1'b0, acc, ov);
      idle(DEPTH, 1'b0);
      check("bubble_occupancy", 32'(occupancy), 32'(2));
      check("bubble_out_valid", 32'(out_valid), 32'(1));
      check("bubble_stacked", 32'(dut.v), 32'(4'b1100));
      idle(DEPTH + 2, 1'b1);
      check("bubble_drained", 32'(q.size()), 32'(0));

      // randomized traffic, holding data while stalled
      have = 1'b0;
      pend = '0;
      for (int i = 0; i < 3000; i++) begin
         bit fl;
         if (!have && ($urandom_range(0, 99) < 65)) begin
            have = 1'b1;
            pend = 8'($urandom);
         end
         fl = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
         fl = ($urandom_range(0, 99) < 2);
`endif
         step(have, pend, ($urandom_range(0, 99) < 60), fl, acc, ov);
         if (acc || fl) have = 1'b0;
      end
      idle(DEPTH + 3, 1'b1);
      check("random_drained", 32'(q.size()), 32'(0));

      // asynchronous reset with three words in flight
      for (int i = 0; i < 3; i++) step(1'b1, 8'h81 + 8'(i), 1'b0, 1'b0, acc, ov);
      in_valid = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'(0));
      check("async_rst_occupancy", 32'(occupancy), 32'(0));
      check("async_rst_out_data", 32'(out_data), 32'(RST_VAL));
      q.delete();
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("async_rst_in_ready", 32'(in_ready), 32'(1));
      step(1'b1, 8'h90, 1'b1, 1'b0, acc, ov);
      measure_latency(lat);
      check("after_reset_latency", 32'(lat), 32'(DEPTH));

`ifdef REG_PIPE_FLUSH_EN
      for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, acc, ov);
      step(1'b1, 8'hEE, 1'b0, 1'b1, acc, ov);
      check("flush_occupancy", 32'(occupancy), 32'(0));
      check("flush_out_valid", 32'(out_valid), 32'(0));
      step(1'b1, 8'h5A, 1'b1, 1'b0, acc, ov);
      measure_latency(lat);
      check("flush_latency", 32'(lat), 32'(DEPTH));
`endif

      idle(DEPTH + 2, 1'b1);
      check("final_drained", 32'(q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
